memory_unit: RTL
================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter DEPTH, 256, number of implemented bytes; addresses 0..DEPTH-1 valid; DEPTH a power of two, maximum 4096.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 M_addr  input  12  CPU byte address.
REQ-005 M_data_out  input  8  CPU write data.
REQ-006 Write_read  input  1  CPU strobe: 1 = write, 0 = read.
REQ-007 M_data_in  output  8  registered read data to the CPU.
REQ-008 ld_valid  input  1  loader byte valid.
REQ-009 ld_data  input  8  loader byte.
REQ-010 ld_last  input  1  marks the final loader byte; qualified by ld_valid.
REQ-011 ld_ready  output  1  loader byte accepted when ld_valid && ld_ready.
REQ-012 reload  input  1  single-cycle request to re-enter program load.
REQ-013 cpu_run  output  1  drives the CPU's active-low reset: 0 holds the CPU in reset, 1 lets it run.
REQ-014 mstate  output  2  current state encoding.
REQ-015 addr_err  output  1  sticky out-of-range access flag.

Function
REQ-016 States: LOAD=2'b00, RUN=2'b01, FAULT=2'b10; 2'b11 unreachable, and if ever entered goes to LOAD on the next cycle.
REQ-017 LOAD: ld_ready=1, cpu_run=0; each handshake writes ld_data to mem[ptr], then ptr increments by 1.
REQ-018 LOAD -> RUN on the cycle after a handshake with ld_last=1, or after the handshake that writes ptr=DEPTH-1 (full); ptr then holds.
REQ-019 RUN: ld_ready=0, cpu_run=1; loader inputs are ignored.
REQ-020 RUN: Write_read=1 with M_addr<DEPTH writes M_data_out to mem[M_addr] at the clock edge; writes with Write_read=0, or in LOAD or FAULT, never take effect.
REQ-021 M_data_in updates every cycle in every state to mem[M_addr], with 1-cycle latency.
REQ-022 Write-first: if a CPU or loader write targets the address being read in the same cycle, M_data_in takes the new byte.
REQ-023 Out of range (M_addr>=DEPTH) in RUN: write suppressed; M_data_in=8'hFF; addr_err set the next cycle and held until reset or reload.
REQ-024 reload=1 in RUN or FAULT: next state LOAD; ptr=0; cpu_run=0 the next cycle; addr_err cleared; a CPU write in the same cycle is suppressed.
REQ-025 reload=1 in LOAD: ptr=0; any same-cycle loader handshake is discarded and ld_ready stays 1.
REQ-026 Memory contents are not cleared by reset or reload.

Reset
REQ-027 Reset has priority over all inputs; next state LOAD, ptr=0.
REQ-028 Reset values: M_data_in=8'h00, ld_ready=1, cpu_run=0, mstate=2'b00, addr_err=0.
REQ-029 A loader handshake or CPU write in the reset cycle is discarded.

Configuration
REQ-030 Macro MEMU_ERR_HALT_EN defined: an out-of-range access in RUN moves the block to FAULT the next cycle; FAULT has cpu_run=0 and ld_ready=0, and is left only by reset or reload.
REQ-031 Macro MEMU_ERR_HALT_EN undefined: FAULT is never entered; an out-of-range access only sets addr_err and the CPU keeps running.

Verification
REQ-032 Load bytes 8'h1A, 8'h2B, 8'hC3 (last on 8'hC3) -> state RUN, cpu_run=1 one cycle after the third handshake; M_addr=0 -> M_data_in=8'h1A one cycle later.
REQ-033 RUN, M_addr=12'h010, Write_read=1, M_data_out=8'h55 -> next-cycle M_data_in=8'h55 (bypass); after Write_read=0 the same address still reads 8'h55.
REQ-034 DEPTH=256, RUN, M_addr=12'h100, Write_read=1, M_data_out=8'h77 -> M_data_in=8'hFF, addr_err=1, mem[0] unchanged; with MEMU_ERR_HALT_EN, mstate=2'b10 and cpu_run=0.
REQ-035 Load DEPTH bytes with ld_last=0 -> RUN entered after byte DEPTH-1; extra ld_valid ignored, ld_ready=0.
REQ-036 reload with a same-cycle CPU write to 12'h005 of 8'h99 -> mem[5] unchanged, state LOAD, addr_err=0, ptr=0.
REQ-037 Reset asserted mid-load after 2 bytes -> ptr=0, outputs at reset values, the next load writes from address 0.

Source files
------------

// File: rtl/memory_unit_if.sv
// memory_unit_if: CPU bus, program loader stream and status lines of memory_unit.
interface memory_unit_if;
    logic [11:0] M_addr;
    logic [7:0]  M_data_out;
    logic        Write_read;
    logic [7:0]  M_data_in;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        reload;
    logic        cpu_run;
    logic [1:0]  mstate;
    logic        addr_err;
    modport master (
        output M_addr, M_data_out, Write_read, ld_valid, ld_data, ld_last, reload,
        input  M_data_in, ld_ready, cpu_run, mstate, addr_err
    );
    modport slave (
        input  M_addr, M_data_out, Write_read, ld_valid, ld_data, ld_last, reload,
        output M_data_in, ld_ready, cpu_run, mstate, addr_err
    );
endinterface

// File: rtl/memory_unit.sv
// memory_unit: loader-filled byte memory that then serves a CPU and releases its reset.
// Define MEMU_ERR_HALT_EN to halt the CPU in FAULT on an out-of-range access.
module memory_unit #(
    parameter int DEPTH = 256
) (
    input logic          clk,
    input logic          reset,
    memory_unit_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {LOAD = 2'b00, RUN = 2'b01, FAULT = 2'b10, BAD = 2'b11} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ld_ready_q, cpu_run_q;
    logic [7:0]    mem_q [DEPTH];
    logic          in_range, ld_fire, cpu_fire, we, full;
    logic [AW-1:0] waddr, raddr;
    logic [7:0]    wdata;
    assign in_range = {1'b0, bus.M_addr} < 13'(DEPTH);
    assign raddr    = bus.M_addr[AW-1:0];
    assign full     = ptr_q == AW'(DEPTH - 1);
    always_comb begin
        ld_fire  = !reset && state_q == LOAD && bus.ld_valid && !bus.reload;
        cpu_fire = !reset && state_q == RUN && bus.Write_read && in_range && !bus.reload;
        we       = ld_fire || cpu_fire;
        waddr    = ld_fire ? ptr_q : raddr;
        wdata    = ld_fire ? bus.ld_data : bus.M_data_out;
        // write-first: a same-cycle write to the read address is forwarded
        rdata_d  = !in_range ? 8'hFF : (we && waddr == raddr) ? wdata : mem_q[raddr];
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        case (state_q)
            LOAD: begin
                if (bus.reload) begin
                    ptr_d = '0;
                end else if (bus.ld_valid) begin
                    ptr_d   = full ? ptr_q : ptr_q + 1'b1;
                    state_d = (bus.ld_last || full) ? RUN : LOAD;
                end
            end
            RUN: begin
                if (bus.reload) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end else if (!in_range) begin
                    err_d = 1'b1;
`ifdef MEMU_ERR_HALT_EN
                    state_d = FAULT;
`endif
                end
            end
            FAULT: begin
                if (bus.reload) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= 8'h00;
            ld_ready_q <= 1'b1;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ld_ready_q <= state_d == LOAD;
            cpu_run_q  <= state_d == RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign bus.M_data_in = rdata_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.cpu_run   = cpu_run_q;
    assign bus.mstate    = state_q;
    assign bus.addr_err  = err_q;
endmodule
